multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Multi-cycle control FSM for the processor datapath. It sequences each instruction through
//  IF/ID/EX/MEM/WB and drives every datapath control line (PC, register file, ALU, memory).
//  It also counts retired instructions and flags unsupported opcodes. It sits beside the
//  datapath in processor and replaces the single-cycle combinational control.
// PARAMETERS
//  CNT_W   32   width of retired-instruction counter Instr_Count
// PORTS
//  Clk            in   1      clock, rising edge
//  Reset          in   1      asynchronous, active-high reset
//  Instr          in   32     IR contents; valid from ID onward
//  ALU_zero       in   1      ALU result == 0; used in EX for beq/bne
//  IR_LdEn        out  1      load IR from instruction memory
//  PC_Sel         out  1      0: PC+4, 1: PC+4+(SignExt(Imm)<<2)
//  PC_LdEn        out  1      PC register load enable
//  RF_WrEn        out  1      register file write enable (rd = Instr[20:16])
//  RF_WrData_sel  out  1      0: ALU_Out, 1: MEM_Out
//  RF_B_sel       out  1      0: rt = Instr[15:11], 1: rd = Instr[20:16]
//  ALU_Bin_sel    out  1      0: RF B, 1: immediate
//  ALU_func       out  4      ALU operation code
//  Mem_WrEn       out  1      data memory write enable
//  Illegal        out  1      sticky: unsupported opcode seen since reset
//  State          out  3      current FSM state (debug)
//  Instr_Count    out  CNT_W  instructions retired since reset
// BEHAVIOUR
//  Reset asserted: state=IF immediately, Illegal=0, Instr_Count=0, all enables=0, ALU_func=0.
//  Reset mid-instruction aborts it: no RF/Mem/PC write after Reset rises.
//  States: IF=0, ID=1, EX=2, MEM=3, WB=4. Outputs are Moore, decoded from State and Instr.
//  Decode, opcode = Instr[31:26]:
//   100000 R-type, ALU_func=Instr[3:0]; 110000 addi (0000); 110010 andi (0010);
//   110011 ori (0011); 111000 li (0000, rs=r0); 001111 lw (0000); 011111 sw (0000);
//   111111 b; 000000 beq; 000001 bne (0001, sub); anything else illegal.
//  IF: IR_LdEn=1 -> ID.  ID: all enables 0 -> EX.
//  EX: ALU_func/ALU_Bin_sel/RF_B_sel per op.
//   R/I-ALU -> WB.  lw/sw -> MEM.
//   b: PC_Sel=1, PC_LdEn=1 -> IF.
//   beq: PC_Sel=ALU_zero, PC_LdEn=1 -> IF.  bne: PC_Sel=~ALU_zero, PC_LdEn=1 -> IF.
//   illegal: PC_Sel=0, PC_LdEn=1, set Illegal -> IF.
//  MEM: lw -> WB.  sw: Mem_WrEn=1, RF_B_sel=1, PC_LdEn=1, PC_Sel=0 -> IF.
//  WB: RF_WrEn=1, RF_WrData_sel=(op==lw), PC_LdEn=1, PC_Sel=0 -> IF.
//  ALU_Bin_sel=1 for addi/andi/ori/li/lw/sw; RF_B_sel=1 for sw/beq/bne; else both 0.
//  Hold ALU_func, ALU_Bin_sel and RF_B_sel from EX through MEM/WB so ALU_Out stays stable.
//  Every enable is a single-cycle pulse. PC_LdEn is 1 in exactly one cycle per instruction.
//  Instr_Count += 1 on each PC_LdEn cycle, wrapping modulo 2^CNT_W; illegal ops count too.
//  Cycles per instruction: R/I-ALU 4, lw 5, sw 4, b/beq/bne 3, illegal 3.
// TESTING
//  1. Reset pulse during EX of add -> State=0, RF_WrEn never 1; after release IF, IR_LdEn=1.
//  2. R-type add (op 100000, func 110000) -> States 0,1,2,4; ALU_func=0000;
//     RF_WrEn=1 in cycle 4 only; Instr_Count=1.
//  3. lw -> States 0,1,2,3,4; ALU_Bin_sel=1; RF_WrData_sel=1 in WB; sw -> Mem_WrEn=1 in
//     MEM only; Instr_Count=2.
//  4. beq with ALU_zero=1 -> PC_Sel=1, PC_LdEn=1 in EX; with ALU_zero=0 -> PC_Sel=0.
//     bne is the inverse.
//  5. Opcode 101010 -> Illegal=1 (sticky after later legal ops); no RF/Mem write;
//     PC_LdEn=1 in EX.
//  6. Preload Instr_Count to 2^CNT_W-1 (CNT_W=4 build, 15 instrs) -> wraps to 0 on the 16th.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the processor datapath.
// Steps each instruction through IF/ID/EX/MEM/WB and drives the datapath
// control lines as Moore outputs decoded from the current state and the IR.
// It also counts retired instructions and keeps a sticky illegal-opcode flag.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [31:0]      Instr,
  input  logic             ALU_zero,
  output logic             IR_LdEn,
  output logic             PC_Sel,
  output logic             PC_LdEn,
  output logic             RF_WrEn,
  output logic             RF_WrData_sel,
  output logic             RF_B_sel,
  output logic             ALU_Bin_sel,
  output logic [3:0]       ALU_func,
  output logic             Mem_WrEn,
  output logic             Illegal,
  output logic [2:0]       State,
  output logic [CNT_W-1:0] Instr_Count
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    K_RTYPE,
    K_ALUI,
    K_LW,
    K_SW,
    K_B,
    K_BEQ,
    K_BNE,
    K_ILL
  } kind_t;

  state_t           state_q, state_d;
  logic             illegal_q;
  logic [CNT_W-1:0] cnt_q;

  kind_t            kind;
  logic [3:0]       dec_func;
  logic             dec_bin;
  logic             dec_rfb;

  // Register-field bits are consumed by the datapath, not by control.
  logic unused_instr_bits;
  assign unused_instr_bits = ^Instr[25:4];

  // Opcode decode: instruction class plus the ALU-side controls it needs.
  always_comb begin
    kind     = K_ILL;
    dec_func = 4'b0000;
    dec_bin  = 1'b0;
    dec_rfb  = 1'b0;
    unique case (Instr[31:26])
      6'b100000: begin kind = K_RTYPE; dec_func = Instr[3:0]; end
      6'b110000: begin kind = K_ALUI; dec_func = 4'b0000; dec_bin = 1'b1; end
      6'b110010: begin kind = K_ALUI; dec_func = 4'b0010; dec_bin = 1'b1; end
      6'b110011: begin kind = K_ALUI; dec_func = 4'b0011; dec_bin = 1'b1; end
      6'b111000: begin kind = K_ALUI; dec_func = 4'b0000; dec_bin = 1'b1; end
      6'b001111: begin kind = K_LW;   dec_func = 4'b0000; dec_bin = 1'b1; end
      6'b011111: begin
        kind = K_SW; dec_func = 4'b0000; dec_bin = 1'b1; dec_rfb = 1'b1;
      end
      6'b111111: begin kind = K_B; end
      6'b000000: begin kind = K_BEQ; dec_func = 4'b0001; dec_rfb = 1'b1; end
      6'b000001: begin kind = K_BNE; dec_func = 4'b0001; dec_rfb = 1'b1; end
      default:   begin kind = K_ILL; end
    endcase
  end

  // Next state and Moore outputs; everything held inactive while Reset is high.
  always_comb begin
    state_d       = state_q;
    IR_LdEn       = 1'b0;
    PC_Sel        = 1'b0;
    PC_LdEn       = 1'b0;
    RF_WrEn       = 1'b0;
    RF_WrData_sel = 1'b0;
    RF_B_sel      = 1'b0;
    ALU_Bin_sel   = 1'b0;
    ALU_func      = 4'b0000;
    Mem_WrEn      = 1'b0;
    if (!Reset) begin
      unique case (state_q)
        S_IF: begin
          IR_LdEn = 1'b1;
          state_d = S_ID;
        end
        S_ID: begin
          state_d = S_EX;
        end
        S_EX: begin
          ALU_func    = dec_func;
          ALU_Bin_sel = dec_bin;
          RF_B_sel    = dec_rfb;
          unique case (kind)
            K_RTYPE, K_ALUI: state_d = S_WB;
            K_LW, K_SW:      state_d = S_MEM;
            K_B: begin
              PC_Sel  = 1'b1;
              PC_LdEn = 1'b1;
              state_d = S_IF;
            end
            K_BEQ: begin
              PC_Sel  = ALU_zero;
              PC_LdEn = 1'b1;
              state_d = S_IF;
            end
            K_BNE: begin
              PC_Sel  = ~ALU_zero;
              PC_LdEn = 1'b1;
              state_d = S_IF;
            end
            default: begin
              // Unsupported opcode: skip it by falling through to PC+4.
              PC_LdEn = 1'b1;
              state_d = S_IF;
            end
          endcase
        end
        S_MEM: begin
          // ALU controls stay put so the memory address remains stable.
          ALU_func    = dec_func;
          ALU_Bin_sel = dec_bin;
          RF_B_sel    = dec_rfb;
          if (kind == K_SW) begin
            Mem_WrEn = 1'b1;
            RF_B_sel = 1'b1;
            PC_LdEn  = 1'b1;
            state_d  = S_IF;
          end else begin
            state_d = S_WB;
          end
        end
        S_WB: begin
          ALU_func      = dec_func;
          ALU_Bin_sel   = dec_bin;
          RF_B_sel      = dec_rfb;
          RF_WrEn       = 1'b1;
          RF_WrData_sel = (kind == K_LW);
          PC_LdEn       = 1'b1;
          state_d       = S_IF;
        end
        default: begin
          state_d = S_IF;
        end
      endcase
    end
  end

  // State register; asynchronous reset aborts any instruction in flight.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  // Sticky illegal-opcode flag, set when an unsupported opcode reaches EX.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                                    illegal_q <= 1'b0;
    else if (state_q == S_EX && kind == K_ILL)    illegal_q <= 1'b1;
  end

  // Retired-instruction counter: one tick per PC load, wrapping naturally.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)        cnt_q <= '0;
    else if (PC_LdEn) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign State       = state_q;
  assign Illegal     = illegal_q;
  assign Instr_Count = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus random
// instruction streams compared cycle by cycle against an instruction-level model.
module tb_multicycle_control;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] Instr;
  logic        ALU_zero;

  logic        IR_LdEn, PC_Sel, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel;
  logic [3:0]  ALU_func;
  logic        Mem_WrEn, Illegal;
  logic [2:0]  State;
  logic [31:0] Instr_Count;

  logic        w4_unused_ir, w4_unused_ps, w4_unused_pl, w4_unused_rw, w4_unused_wd;
  logic        w4_unused_rb, w4_unused_bn, w4_unused_mw, w4_unused_il;
  logic [3:0]  w4_unused_fn;
  logic [2:0]  w4_unused_st;
  logic [3:0]  w4_Instr_Count;

  int total = 0;
  int bad   = 0;
  int model_cnt = 0;
  bit model_ill = 1'b0;

  always #5 Clk = ~Clk;

  multicycle_control #(.CNT_W(32)) dut (
    .Clk(Clk), .Reset(Reset), .Instr(Instr), .ALU_zero(ALU_zero),
    .IR_LdEn(IR_LdEn), .PC_Sel(PC_Sel), .PC_LdEn(PC_LdEn), .RF_WrEn(RF_WrEn),
    .RF_WrData_sel(RF_WrData_sel), .RF_B_sel(RF_B_sel), .ALU_Bin_sel(ALU_Bin_sel),
    .ALU_func(ALU_func), .Mem_WrEn(Mem_WrEn), .Illegal(Illegal), .State(State),
    .Instr_Count(Instr_Count)
  );

  multicycle_control #(.CNT_W(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .Instr(Instr), .ALU_zero(ALU_zero),
    .IR_LdEn(w4_unused_ir), .PC_Sel(w4_unused_ps), .PC_LdEn(w4_unused_pl),
    .RF_WrEn(w4_unused_rw), .RF_WrData_sel(w4_unused_wd), .RF_B_sel(w4_unused_rb),
    .ALU_Bin_sel(w4_unused_bn), .ALU_func(w4_unused_fn), .Mem_WrEn(w4_unused_mw),
    .Illegal(w4_unused_il), .State(w4_unused_st), .Instr_Count(w4_Instr_Count)
  );

  // Observed control vector: {IR,PCsel,PCld,RFwr,WDsel,RFBsel,Binsel,func[3:0],MemWr,State}
  logic [14:0] vec;
  assign vec = {IR_LdEn, PC_Sel, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel,
                ALU_func, Mem_WrEn, State};

  localparam logic [5:0] OP_R = 6'b100000, OP_ADDI = 6'b110000, OP_ANDI = 6'b110010,
                         OP_ORI = 6'b110011, OP_LI = 6'b111000, OP_LW = 6'b001111,
                         OP_SW = 6'b011111, OP_B = 6'b111111, OP_BEQ = 6'b000000,
                         OP_BNE = 6'b000001;

  // ---------------- reference model (instruction level) ----------------
  // class: 0 R, 1 ALU-imm, 2 lw, 3 sw, 4 b, 5 beq, 6 bne, 7 illegal
  function automatic int klass(input logic [5:0] op);
    case (op)
      OP_R:                          return 0;
      OP_ADDI, OP_ANDI, OP_ORI, OP_LI: return 1;
      OP_LW:                         return 2;
      OP_SW:                         return 3;
      OP_B:                          return 4;
      OP_BEQ:                        return 5;
      OP_BNE:                        return 6;
      default:                       return 7;
    endcase
  endfunction

  function automatic logic [14:0] pk(input bit ir, input bit ps, input bit pl, input bit rw,
                                     input bit wd, input bit rb, input bit bn,
                                     input logic [3:0] f, input bit mw, input int st);
    return {ir, ps, pl, rw, wd, rb, bn, f, mw, st[2:0]};
  endfunction

  // Expected per-cycle control vectors for one instruction and its cycle count.
  task automatic exp_trace(input logic [31:0] ins, input bit z,
                           output logic [7:0][14:0] e, output int n);
    int k;
    logic [3:0] f;
    bit bn, rb, ps;
    k  = klass(ins[31:26]);
    case (ins[31:26])
      OP_R:            f = ins[3:0];
      OP_ANDI:         f = 4'b0010;
      OP_ORI:          f = 4'b0011;
      OP_BEQ, OP_BNE:  f = 4'b0001;
      default:         f = 4'b0000;
    endcase
    bn = (k == 1 || k == 2 || k == 3);
    rb = (k == 3 || k == 5 || k == 6);
    e  = '0;
    e[0] = pk(1, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0);
    e[1] = pk(0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 1);
    if (k >= 4) begin
      ps = (k == 4) ? 1'b1 : (k == 5) ? z : (k == 6) ? ~z : 1'b0;
      e[2] = pk(0, ps, 1, 0, 0, rb, bn, f, 0, 2);
      n = 3;
    end else begin
      e[2] = pk(0, 0, 0, 0, 0, rb, bn, f, 0, 2);
      if (k == 2) begin
        e[3] = pk(0, 0, 0, 0, 0, rb, bn, f, 0, 3);
        e[4] = pk(0, 0, 1, 1, 1, rb, bn, f, 0, 4);
        n = 5;
      end else if (k == 3) begin
        e[3] = pk(0, 0, 1, 0, 0, 1, bn, f, 1, 3);
        n = 4;
      end else begin
        e[3] = pk(0, 0, 1, 1, 0, rb, bn, f, 0, 4);
        n = 4;
      end
    end
  endtask

  // Drive one instruction from IF and record vectors until the PC load (bounded).
  task automatic run_instr(input logic [31:0] ins, input bit z,
                           output logic [7:0][14:0] o, output int n);
    Instr    = ins;
    ALU_zero = z;
    o = '0;
    n = 8;
    for (int c = 0; c < 8; c++) begin
      @(negedge Clk);
      o[c] = vec;
      @(posedge Clk); #1;
      if (o[c][12] === 1'b1) begin
        n = c + 1;
        break;
      end
    end
    if (klass(ins[31:26]) == 7) model_ill = 1'b1;
    model_cnt++;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    model_cnt = 0;
    model_ill = 1'b0;
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [25:0] low);
    return {op, low};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    Instr = 32'd0; ALU_zero = 1'b0; Reset = 1'b1;
    @(posedge Clk); #1;
    @(negedge Clk);
    total++; if (vec !== 15'd0) begin bad++; $display("FAIL reset_outputs got=%h want=%h", vec, 15'd0); end
    total++; if (Instr_Count !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", Instr_Count); end
    total++; if (Illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b want=0", Illegal); end
    total++; if (w4_Instr_Count !== 4'd0) begin bad++; $display("FAIL reset_count4 got=%0d want=0", w4_Instr_Count); end
    @(posedge Clk); #1;
    Reset = 1'b0;
    model_cnt = 0; model_ill = 1'b0;
    #1;
    total++; if (IR_LdEn !== 1'b1 || State !== 3'd0) begin bad++; $display("FAIL reset_release got=%b/%0d want=1/0", IR_LdEn, State); end
  endtask

  task automatic test_reset_mid();
    bit rfw_seen;
    logic [7:0][14:0] o, e;
    int no, ne;
    logic [31:0] add_i;
    do_reset();
    add_i = mk(OP_R, 26'h0000030);
    Instr = add_i; ALU_zero = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    @(negedge Clk);
    total++; if (State !== 3'd2) begin bad++; $display("FAIL midreset_in_ex got=%0d want=2", State); end
    Reset = 1'b1;
    rfw_seen = 1'b0;
    #1;
    total++; if (State !== 3'd0) begin bad++; $display("FAIL midreset_state got=%0d want=0", State); end
    for (int c = 0; c < 3; c++) begin
      if (RF_WrEn !== 1'b0 || PC_LdEn !== 1'b0 || Mem_WrEn !== 1'b0) rfw_seen = 1'b1;
      @(posedge Clk); #1;
    end
    total++; if (rfw_seen) begin bad++; $display("FAIL midreset_no_write got=1 want=0"); end
    total++; if (Instr_Count !== 32'd0) begin bad++; $display("FAIL midreset_count got=%0d want=0", Instr_Count); end
    Reset = 1'b0;
    model_cnt = 0; model_ill = 1'b0;
    #1;
    total++; if (State !== 3'd0 || IR_LdEn !== 1'b1) begin bad++; $display("FAIL midreset_release got=%0d/%b want=0/1", State, IR_LdEn); end
    run_instr(add_i, 1'b0, o, no);
    exp_trace(add_i, 1'b0, e, ne);
    total++; if (no !== ne) begin bad++; $display("FAIL midreset_redo_cycles got=%0d want=%0d", no, ne); end
    for (int c = 0; c < ne; c++) begin
      total++; if (o[c] !== e[c]) begin bad++; $display("FAIL midreset_redo_c%0d got=%h want=%h", c, o[c], e[c]); end
    end
  endtask

  task automatic test_rtype();
    logic [7:0][14:0] o, e;
    int no, ne;
    logic [31:0] ins;
    do_reset();
    ins = mk(OP_R, {20'h12345, 6'b110000});
    run_instr(ins, 1'b1, o, no);
    exp_trace(ins, 1'b1, e, ne);
    total++; if (no !== ne) begin bad++; $display("FAIL rtype_cycles got=%0d want=%0d", no, ne); end
    for (int c = 0; c < ne; c++) begin
      total++; if (o[c] !== e[c]) begin bad++; $display("FAIL rtype_c%0d got=%h want=%h", c, o[c], e[c]); end
    end
    total++; if (Instr_Count !== 32'(model_cnt)) begin bad++; $display("FAIL rtype_count got=%0d want=%0d", Instr_Count, model_cnt); end
  endtask

  task automatic test_lw_sw();
    logic [7:0][14:0] o, e;
    int no, ne;
    logic [31:0] ins [2];
    ins[0] = mk(OP_LW, 26'h1A2B3C4);
    ins[1] = mk(OP_SW, 26'h0F0F0F0);
    for (int i = 0; i < 2; i++) begin
      run_instr(ins[i], 1'b0, o, no);
      exp_trace(ins[i], 1'b0, e, ne);
      total++; if (no !== ne) begin bad++; $display("FAIL lwsw%0d_cycles got=%0d want=%0d", i, no, ne); end
      for (int c = 0; c < ne; c++) begin
        total++; if (o[c] !== e[c]) begin bad++; $display("FAIL lwsw%0d_c%0d got=%h want=%h", i, c, o[c], e[c]); end
      end
      total++; if (Instr_Count !== 32'(model_cnt)) begin bad++; $display("FAIL lwsw%0d_count got=%0d want=%0d", i, Instr_Count, model_cnt); end
    end
  endtask

  task automatic test_branches();
    logic [7:0][14:0] o, e;
    int no, ne;
    logic [31:0] ins;
    for (int i = 0; i < 6; i++) begin
      ins = mk((i < 2) ? OP_BEQ : (i < 4) ? OP_BNE : OP_B, 26'(32'h00ABCD + i));
      run_instr(ins, i[0], o, no);
      exp_trace(ins, i[0], e, ne);
      total++; if (no !== ne) begin bad++; $display("FAIL br%0d_cycles got=%0d want=%0d", i, no, ne); end
      for (int c = 0; c < ne; c++) begin
        total++; if (o[c] !== e[c]) begin bad++; $display("FAIL br%0d_c%0d got=%h want=%h", i, c, o[c], e[c]); end
      end
    end
  endtask

  task automatic test_illegal();
    logic [7:0][14:0] o, e;
    int no, ne;
    logic [31:0] ins;
    total++; if (Illegal !== 1'b0) begin bad++; $display("FAIL illegal_before got=%b want=0", Illegal); end
    ins = mk(6'b101010, 26'h3FFFFFF);
    run_instr(ins, 1'b0, o, no);
    exp_trace(ins, 1'b0, e, ne);
    total++; if (no !== ne) begin bad++; $display("FAIL illegal_cycles got=%0d want=%0d", no, ne); end
    for (int c = 0; c < ne; c++) begin
      total++; if (o[c] !== e[c]) begin bad++; $display("FAIL illegal_c%0d got=%h want=%h", c, o[c], e[c]); end
    end
    total++; if (Illegal !== 1'b1) begin bad++; $display("FAIL illegal_set got=%b want=1", Illegal); end
    ins = mk(OP_ADDI, 26'h0000123);
    run_instr(ins, 1'b0, o, no);
    total++; if (Illegal !== model_ill) begin bad++; $display("FAIL illegal_sticky got=%b want=%b", Illegal, model_ill); end
    total++; if (Instr_Count !== 32'(model_cnt)) begin bad++; $display("FAIL illegal_count got=%0d want=%0d", Instr_Count, model_cnt); end
  endtask

  task automatic test_random();
    logic [7:0][14:0] o, e;
    int no, ne;
    logic [31:0] ins;
    logic [5:0] ops [10];
    logic [5:0] op;
    bit z;
    ops = '{OP_R, OP_ADDI, OP_ANDI, OP_ORI, OP_LI, OP_LW, OP_SW, OP_B, OP_BEQ, OP_BNE};
    do_reset();
    for (int i = 0; i < 40; i++) begin
      int idx;
      idx = $urandom_range(0, 11);
      if (idx < 10) op = ops[idx];
      else begin
        op = 6'($urandom);
        while (klass(op) != 7) op = 6'($urandom);
      end
      ins = mk(op, 26'($urandom));
      z   = 1'($urandom_range(0, 1));
      run_instr(ins, z, o, no);
      exp_trace(ins, z, e, ne);
      total++; if (no !== ne) begin bad++; $display("FAIL rnd%0d_cycles op=%b got=%0d want=%0d", i, op, no, ne); end
      for (int c = 0; c < ne; c++) begin
        total++; if (o[c] !== e[c]) begin bad++; $display("FAIL rnd%0d_c%0d op=%b got=%h want=%h", i, c, op, o[c], e[c]); end
      end
      total++; if (Instr_Count !== 32'(model_cnt) || Illegal !== model_ill) begin
        bad++; $display("FAIL rnd%0d_status got=%0d/%b want=%0d/%b", i, Instr_Count, Illegal, model_cnt, model_ill);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0][14:0] o;
    int no;
    do_reset();
    for (int i = 0; i < 15; i++) run_instr(mk(OP_R, 26'(i)), 1'b0, o, no);
    total++; if (w4_Instr_Count !== 4'(model_cnt)) begin bad++; $display("FAIL wrap_pre got=%0d want=%0d", w4_Instr_Count, 4'(model_cnt)); end
    run_instr(mk(OP_BEQ, 26'd0), 1'b1, o, no);
    total++; if (w4_Instr_Count !== 4'(model_cnt)) begin bad++; $display("FAIL wrap_post got=%0d want=%0d", w4_Instr_Count, 4'(model_cnt)); end
    total++; if (Instr_Count !== 32'(model_cnt)) begin bad++; $display("FAIL wrap_wide got=%0d want=%0d", Instr_Count, model_cnt); end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_rtype();
    test_lw_sw();
    test_branches();
    test_illegal();
    test_random();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
